// File: rtl/roce_cm_rep_tx_gen.sv
// rtl/roce_cm_rep_tx_gen.sv - builds one RoCEv2 CM ConnectReply frame per parsed ConnectRequest
// A single request can be held pending while a frame is in flight; further requests are counted as drops.
module roce_cm_rep_tx_gen #(
    parameter int          C_AXIS_DATA_WIDTH = 512,
    parameter logic [15:0] UDP_SRC_PORT      = 16'hC000
) (
    input  logic                             core_clk,
    input  logic                             core_aresetn,
    input  logic                             CM_Req_tvalid,
    input  logic                             CM_ReadyToUse_tvalid,
    input  logic [47:0]                      recv_CM_src_mac,
    input  logic [31:0]                      recv_CM_src_ip,
    input  logic [63:0]                      recv_MAD_Transaction_ID,
    input  logic [31:0]                      recv_CM_local_Comm_ID,
    input  logic [23:0]                      recv_CM_QPN,
    input  logic [23:0]                      recv_QPn_start_PSN,
    input  logic [47:0]                      cfg_local_mac,
    input  logic [31:0]                      cfg_local_ip,
    input  logic [23:0]                      cfg_local_qpn,
    input  logic [23:0]                      cfg_start_psn,
    input  logic [63:0]                      cfg_ca_guid,
    output logic [C_AXIS_DATA_WIDTH-1:0]     tx_m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]   tx_m_axis_tkeep,
    output logic                             tx_m_axis_tvalid,
    output logic                             tx_m_axis_tlast,
    input  logic                             tx_m_axis_tready,
    output logic                             qp_conn_valid,
    output logic [23:0]                      qp_conn_remote_qpn,
    output logic [23:0]                      qp_conn_remote_psn,
    output logic [15:0]                      rep_drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_SEND} state_t;

    typedef struct packed {
        logic [47:0] rmac;
        logic [31:0] rip;
        logic [63:0] tid;
        logic [31:0] rcomm;
        logic [23:0] rqpn;
        logic [23:0] rpsn;
        logic [47:0] lmac;
        logic [31:0] lip;
        logic [23:0] lqpn;
        logic [23:0] lpsn;
        logic [63:0] guid;
    } ctx_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q;
    ctx_t        ctx_q, pend_q, req_ctx;
    logic        pend_valid_q;
    logic [31:0] comm_id_q;
    logic [15:0] ip_csum_q;
    logic        busy, hs, last_hs, consume;

    logic [31:0] csum_sum;
    logic [16:0] csum_fold1;
    logic [15:0] csum_fold2;

    logic [0:5][511:0] frame_beats;

    assign req_ctx = '{rmac: recv_CM_src_mac, rip: recv_CM_src_ip, tid: recv_MAD_Transaction_ID,
                       rcomm: recv_CM_local_Comm_ID, rqpn: recv_CM_QPN, rpsn: recv_QPn_start_PSN,
                       lmac: cfg_local_mac, lip: cfg_local_ip, lqpn: cfg_local_qpn,
                       lpsn: cfg_start_psn, guid: cfg_ca_guid};

    assign busy    = (state_q != S_IDLE);
    assign hs      = tx_m_axis_tvalid && tx_m_axis_tready;
    assign last_hs = (state_q == S_SEND) && hs && (beat_q == 3'd5);
    assign consume = last_hs && pend_valid_q;

    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (CM_Req_tvalid) state_d = S_PREP;
            S_PREP:  state_d = S_SEND;
            S_SEND:  if (last_hs) state_d = pend_valid_q ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Constant header words 4500+0134+0000+4000+4011 pre-summed to C645; checksum field counts as 0.
    always_comb begin
        csum_sum   = 32'h0000_C645
                   + {16'h0, ctx_q.lip[31:16]} + {16'h0, ctx_q.lip[15:0]}
                   + {16'h0, ctx_q.rip[31:16]} + {16'h0, ctx_q.rip[15:0]};
        csum_fold1 = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
        csum_fold2 = csum_fold1[15:0] + {15'h0, csum_fold1[16]};
    end

    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            ctx_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            beat_q       <= 3'd0;
            comm_id_q    <= 32'h1;
            ip_csum_q    <= 16'h0;
            rep_drop_cnt <= 16'h0;
        end else begin
            if (state_q == S_IDLE && CM_Req_tvalid) begin
                ctx_q <= req_ctx;
            end else if (consume) begin
                ctx_q <= pend_q;
            end

            // A request arriving as the pending slot drains takes that slot over.
            if (busy && CM_Req_tvalid && (!pend_valid_q || consume)) begin
                pend_q       <= req_ctx;
                pend_valid_q <= 1'b1;
            end else if (consume) begin
                pend_valid_q <= 1'b0;
            end

            if (busy && CM_Req_tvalid && pend_valid_q && !consume && rep_drop_cnt != 16'hFFFF) begin
                rep_drop_cnt <= rep_drop_cnt + 16'h1;
            end

            if (state_q == S_PREP) begin
                beat_q    <= 3'd0;
                ip_csum_q <= ~csum_fold2;
            end else if (state_q == S_SEND && hs) begin
                beat_q <= (beat_q == 3'd5) ? 3'd0 : beat_q + 3'd1;
            end

            if (last_hs) begin
                comm_id_q <= (comm_id_q == 32'hFFFF_FFFF) ? 32'h1 : comm_id_q + 32'h1;
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            qp_conn_valid      <= 1'b0;
            qp_conn_remote_qpn <= 24'h0;
            qp_conn_remote_psn <= 24'h0;
        end else begin
            qp_conn_valid <= CM_ReadyToUse_tvalid;
            if (CM_ReadyToUse_tvalid) begin
                qp_conn_remote_qpn <= ctx_q.rqpn;
                qp_conn_remote_psn <= ctx_q.rpsn;
            end
        end
    end

    // Bytes 0..117 carry fields; the remaining MAD payload, ICRC bytes and pad are zero.
    assign frame_beats = {
        ctx_q.rmac, ctx_q.lmac, 16'h0800,
        16'h4500, 16'h0134, 16'h0000, 16'h4000, 16'h4011, ip_csum_q, ctx_q.lip, ctx_q.rip,
        UDP_SRC_PORT, 16'h12B7, 16'h0120, 16'h0000,
        8'h64, 8'h00, 16'hFFFF, 8'h00, 24'h000001, 8'h00, 24'h000000,
        32'h8001_0000, 8'h00, 24'h000001,
        32'h0107_0203, 16'h0000, 16'h0000, ctx_q.tid, 16'h0013, 16'h0000, 32'h0000_0000,
        comm_id_q, ctx_q.rcomm, 32'h0000_0000, ctx_q.lqpn, 8'h00, ctx_q.lpsn, 40'h0, ctx_q.guid,
        {2128{1'b0}}
    };

    always_comb begin
        tx_m_axis_tvalid = (state_q == S_SEND);
        tx_m_axis_tlast  = 1'b0;
        tx_m_axis_tdata  = '0;
        tx_m_axis_tkeep  = '0;
        if (state_q == S_SEND) begin
            tx_m_axis_tdata = frame_beats[beat_q];
            tx_m_axis_tlast = (beat_q == 3'd5);
            tx_m_axis_tkeep = (beat_q == 3'd5) ? 64'hC000_0000_0000_0000 : '1;
        end
    end

endmodule

// File: tb/tb_roce_cm_rep_tx_gen.sv
// tb/tb_roce_cm_rep_tx_gen.sv - scoreboard bench for roce_cm_rep_tx_gen
module tb_roce_cm_rep_tx_gen;

    logic         core_clk = 1'b0;
    logic         core_aresetn = 1'b0;
    logic         CM_Req_tvalid = 1'b0;
    logic         CM_ReadyToUse_tvalid = 1'b0;
    logic [47:0]  recv_CM_src_mac = '0;
    logic [31:0]  recv_CM_src_ip = '0;
    logic [63:0]  recv_MAD_Transaction_ID = '0;
    logic [31:0]  recv_CM_local_Comm_ID = '0;
    logic [23:0]  recv_CM_QPN = '0;
    logic [23:0]  recv_QPn_start_PSN = '0;
    logic [47:0]  cfg_local_mac = 48'h02_00_00_00_00_01;
    logic [31:0]  cfg_local_ip = 32'hC0A8_0101;
    logic [23:0]  cfg_local_qpn = 24'h000055;
    logic [23:0]  cfg_start_psn = 24'h123456;
    logic [63:0]  cfg_ca_guid = 64'h0002_C903_00AB_CDEF;
    logic [511:0] tx_m_axis_tdata;
    logic [63:0]  tx_m_axis_tkeep;
    logic         tx_m_axis_tvalid;
    logic         tx_m_axis_tlast;
    logic         tx_m_axis_tready;
    logic         qp_conn_valid;
    logic [23:0]  qp_conn_remote_qpn;
    logic [23:0]  qp_conn_remote_psn;
    logic [15:0]  rep_drop_cnt;

    logic tr_toggle = 1'b0;
    logic tr_fix = 1'b1;
    logic tog = 1'b0;

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) tog <= ~tog;
    assign tx_m_axis_tready = tr_toggle ? tog : tr_fix;

    roce_cm_rep_tx_gen dut (
        .core_clk                (core_clk),
        .core_aresetn            (core_aresetn),
        .CM_Req_tvalid           (CM_Req_tvalid),
        .CM_ReadyToUse_tvalid    (CM_ReadyToUse_tvalid),
        .recv_CM_src_mac         (recv_CM_src_mac),
        .recv_CM_src_ip          (recv_CM_src_ip),
        .recv_MAD_Transaction_ID (recv_MAD_Transaction_ID),
        .recv_CM_local_Comm_ID   (recv_CM_local_Comm_ID),
        .recv_CM_QPN             (recv_CM_QPN),
        .recv_QPn_start_PSN      (recv_QPn_start_PSN),
        .cfg_local_mac           (cfg_local_mac),
        .cfg_local_ip            (cfg_local_ip),
        .cfg_local_qpn           (cfg_local_qpn),
        .cfg_start_psn           (cfg_start_psn),
        .cfg_ca_guid             (cfg_ca_guid),
        .tx_m_axis_tdata         (tx_m_axis_tdata),
        .tx_m_axis_tkeep         (tx_m_axis_tkeep),
        .tx_m_axis_tvalid        (tx_m_axis_tvalid),
        .tx_m_axis_tlast         (tx_m_axis_tlast),
        .tx_m_axis_tready        (tx_m_axis_tready),
        .qp_conn_valid           (qp_conn_valid),
        .qp_conn_remote_qpn      (qp_conn_remote_qpn),
        .qp_conn_remote_psn      (qp_conn_remote_psn),
        .rep_drop_cnt            (rep_drop_cnt)
    );

    typedef struct {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [63:0] tid;
        logic [31:0] comm;
        logic [23:0] qpn;
        logic [23:0] psn;
    } req_t;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        int           gap;
    } beat_t;

    beat_t        sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  exp_comm_id = 32'h1;
    logic [511:0] cap0 = '0;
    logic [511:0] cap1 = '0;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3071:0] model_frame(input req_t r, input logic [31:0] lcid);
        logic [7:0]    b [0:383];
        logic [31:0]   s;
        logic [3071:0] f;
        for (int i = 0; i < 384; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]     = r.mac[47-8*i -: 8];
            b[6+i]   = cfg_local_mac[47-8*i -: 8];
        end
        b[12] = 8'h08;
        b[14] = 8'h45; b[16] = 8'h01; b[17] = 8'h34; b[20] = 8'h40; b[22] = 8'h40; b[23] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            b[26+i] = cfg_local_ip[31-8*i -: 8];
            b[30+i] = r.ip[31-8*i -: 8];
            b[86+i] = lcid[31-8*i -: 8];
            b[90+i] = r.comm[31-8*i -: 8];
        end
        b[34] = 8'hC0; b[36] = 8'h12; b[37] = 8'hB7; b[38] = 8'h01; b[39] = 8'h20;
        b[42] = 8'h64; b[44] = 8'hFF; b[45] = 8'hFF; b[49] = 8'h01;
        b[54] = 8'h80; b[55] = 8'h01; b[61] = 8'h01;
        b[62] = 8'h01; b[63] = 8'h07; b[64] = 8'h02; b[65] = 8'h03;
        for (int i = 0; i < 8; i++) begin
            b[70+i]  = r.tid[63-8*i -: 8];
            b[110+i] = cfg_ca_guid[63-8*i -: 8];
        end
        b[79] = 8'h13;
        for (int i = 0; i < 3; i++) begin
            b[98+i]  = cfg_local_qpn[23-8*i -: 8];
            b[102+i] = cfg_start_psn[23-8*i -: 8];
        end
        s = 32'h0;
        for (int i = 0; i < 10; i++) s = s + {16'h0, b[14+2*i], b[15+2*i]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        b[24] = ~s[15:8];
        b[25] = ~s[7:0];
        for (int i = 0; i < 384; i++) f[3071-8*i -: 8] = b[i];
        return f;
    endfunction

    task automatic push_frame(input req_t r, input int gap);
        logic [3071:0] f;
        beat_t e;
        f = model_frame(r, exp_comm_id);
        for (int k = 0; k < 6; k++) begin
            e.data = f[3071-512*k -: 512];
            e.keep = (k == 5) ? 64'hC000_0000_0000_0000 : {64{1'b1}};
            e.last = (k == 5);
            e.gap  = (k == 0) ? gap : 0;
            sb.push_back(e);
        end
        exp_comm_id = (exp_comm_id == 32'hFFFF_FFFF) ? 32'h1 : exp_comm_id + 32'h1;
    endtask

    task automatic send_req(input req_t r, input bit expect_frame, input int gap);
        @(posedge core_clk);
        #1;
        recv_CM_src_mac         = r.mac;
        recv_CM_src_ip          = r.ip;
        recv_MAD_Transaction_ID = r.tid;
        recv_CM_local_Comm_ID   = r.comm;
        recv_CM_QPN             = r.qpn;
        recv_QPn_start_PSN      = r.psn;
        CM_Req_tvalid           = 1'b1;
        if (expect_frame) push_frame(r, gap);
        @(posedge core_clk);
        #1;
        CM_Req_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge core_clk);
            n++;
        end
        repeat (2) @(posedge core_clk);
        check_val(tag, sb.size(), 0);
    endtask

    int           cyc = 0;
    int           last_tlast_cyc = 0;
    int           beat_idx = 0;
    logic         prev_stall = 1'b0;
    logic [511:0] prev_data = '0;

    always @(negedge core_clk) begin
        beat_t e;
        cyc++;
        if (!core_aresetn) begin
            prev_stall = 1'b0;
            beat_idx   = 0;
        end else if (tx_m_axis_tvalid) begin
            if (prev_stall) check_val("stall_stable", tx_m_axis_tdata, prev_data);
            if (tx_m_axis_tready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_beat", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_val("tdata", tx_m_axis_tdata, e.data);
                    check_val("tkeep", tx_m_axis_tkeep, e.keep);
                    check_val("tlast", tx_m_axis_tlast, e.last);
                    if (e.gap != 0) check_val("prep_gap", cyc - last_tlast_cyc, e.gap);
                end
                if (beat_idx == 0) cap0 = tx_m_axis_tdata;
                if (beat_idx == 1) cap1 = tx_m_axis_tdata;
                if (tx_m_axis_tlast) begin
                    last_tlast_cyc = cyc;
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            prev_stall = !tx_m_axis_tready;
            prev_data  = tx_m_axis_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        req_t r1, r2, r3, r4;
        int   n;
        r1 = '{mac: 48'h02_00_00_00_00_AA, ip: 32'hC0A8_010A, tid: 64'h1122_3344_5566_7788,
               comm: 32'hA5A5_0001, qpn: 24'h000077, psn: 24'h000100};
        r2 = '{mac: 48'h02_00_00_00_00_BB, ip: 32'h0A00_0002, tid: 64'hCAFE_0000_0000_0002,
               comm: 32'h0000_0B0B, qpn: 24'h000200, psn: 24'h00FFFF};
        r3 = '{mac: 48'h02_00_00_00_00_CC, ip: 32'h0A00_0003, tid: 64'hCAFE_0000_0000_0003,
               comm: 32'h0000_0C0C, qpn: 24'h000300, psn: 24'h000003};
        r4 = '{mac: 48'h02_00_00_00_00_DD, ip: 32'hAC10_0004, tid: 64'h0000_0000_DEAD_BEEF,
               comm: 32'h1234_5678, qpn: 24'h000123, psn: 24'h00ABCD};

        repeat (3) @(posedge core_clk);
        #1;
        check_val("rst_tvalid", tx_m_axis_tvalid, 0);
        check_val("rst_tdata", tx_m_axis_tdata, 0);
        check_val("rst_conn_valid", qp_conn_valid, 0);
        check_val("rst_drop", rep_drop_cnt, 0);
        check_val("rst_rqpn", qp_conn_remote_qpn, 0);
        core_aresetn = 1'b1;

        send_req(r1, 1'b1, 0);
        @(negedge core_clk);
        check_val("lat_prep", tx_m_axis_tvalid, 0);
        @(negedge core_clk);
        check_val("lat_send", tx_m_axis_tvalid, 1);
        wait_drain("drain_t1", 50);
        check_val("ip_csum", cap0[319:304], 16'hB65D);
        check_val("mad_tid", cap1[463:400], 64'h1122_3344_5566_7788);
        check_val("mad_attr", cap1[399:384], 16'h0013);
        check_val("local_comm_id", cap1[335:304], 32'h1);

        tr_toggle = 1'b1;
        send_req(r1, 1'b1, 0);
        wait_drain("drain_t2", 60);
        tr_toggle = 1'b0;

        send_req(r2, 1'b1, 0);
        send_req(r3, 1'b1, 2);
        send_req(r4, 1'b0, 0);
        wait_drain("drain_t3", 80);
        check_val("drop_one", rep_drop_cnt, 1);

        send_req(r4, 1'b1, 0);
        wait_drain("drain_t4", 50);
        @(posedge core_clk);
        #1;
        CM_ReadyToUse_tvalid = 1'b1;
        @(posedge core_clk);
        #1;
        CM_ReadyToUse_tvalid = 1'b0;
        check_val("rtu_valid", qp_conn_valid, 1);
        check_val("rtu_qpn", qp_conn_remote_qpn, 24'h000123);
        check_val("rtu_psn", qp_conn_remote_psn, 24'h00ABCD);
        @(posedge core_clk);
        #1;
        check_val("rtu_pulse_end", qp_conn_valid, 0);

        send_req(r2, 1'b1, 0);
        n = 0;
        while (!tx_m_axis_tvalid && n < 20) begin
            @(negedge core_clk);
            n++;
        end
        check_val("t5_start", tx_m_axis_tvalid, 1);
        repeat (3) @(posedge core_clk);
        #1;
        core_aresetn = 1'b0;
        #1;
        check_val("rst_mid_tvalid", tx_m_axis_tvalid, 0);
        sb.delete();
        exp_comm_id = 32'h1;
        repeat (3) @(posedge core_clk);
        #1;
        core_aresetn = 1'b1;
        @(negedge core_clk);
        check_val("post_rst_idle", tx_m_axis_tvalid, 0);
        check_val("post_rst_drop", rep_drop_cnt, 0);
        send_req(r3, 1'b1, 0);
        wait_drain("drain_t5", 50);

        tr_fix = 1'b0;
        send_req(r1, 1'b1, 0);
        send_req(r2, 1'b1, 0);
        @(posedge core_clk);
        #1;
        CM_Req_tvalid = 1'b1;
        repeat (100) @(posedge core_clk);
        #1;
        check_val("drop_100", rep_drop_cnt, 100);
        repeat (65440) @(posedge core_clk);
        #1;
        CM_Req_tvalid = 1'b0;
        check_val("drop_sat", rep_drop_cnt, 16'hFFFF);
        @(posedge core_clk);
        #1;
        check_val("drop_sat_hold", rep_drop_cnt, 16'hFFFF);

        core_aresetn = 1'b0;
        sb.delete();
        repeat (2) @(posedge core_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
